// File: rtl/ad100_fetch.sv
// ad100_fetch: instruction prefetch stage feeding ad100 decode through a small FIFO.
// Define AD100_FETCH_MISALIGN_EN to trap misaligned redirects in a sticky FAULT state.
module ad100_fetch #(
  parameter int          DEPTH    = 2,
  parameter int          ADDR_W   = 30,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  output logic              fetch_fault
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

  logic [31:0]   fpc_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          inflight_reg;
  logic          live_reg;
  logic [31:0]   flight_pc_reg;
  logic [31:0]   inst_reg;
  logic [31:0]   inst_pc_reg;

  // Each entry packs {pc, instruction word}.
  logic [63:0]   fifo_mem [DEPTH];

  logic          faulted;
  logic          redirect_take;
  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occ;
  logic [PW-1:0] rd_ptr_next;
  logic [PW-1:0] wr_ptr_next;
  logic [63:0]   head_after_pop;
  logic [31:0]   head_data_next;
  logic [31:0]   head_pc_next;

`ifdef AD100_FETCH_MISALIGN_EN
  typedef enum logic {RUN, FAULT} state_t;
  state_t state_reg;
  logic   fault_reg;
  logic   misaligned;

  assign faulted     = (state_reg == FAULT);
  assign misaligned  = (redirect_pc[1:0] != 2'b00);
  assign fetch_fault = fault_reg;
`else
  logic unused_pc_bits;

  assign faulted        = 1'b0;
  assign unused_pc_bits = ^redirect_pc[1:0];
  assign fetch_fault    = 1'b0;
`endif

  assign redirect_take = redirect & ~faulted;
  assign inst_valid    = (count_reg != '0);
  assign pop           = inst_valid & inst_ready;
  // The word arriving in a redirect cycle belongs to the old stream.
  assign push          = inflight_reg & live_reg & ~redirect_take;

  // Buffered + outstanding words after this cycle's pop must leave room for one more.
  assign occ   = {1'b0, count_reg}
               + {{CW{1'b0}}, inflight_reg}
               - {{CW{1'b0}}, pop};
  assign issue = ~rst & ~faulted & ~redirect_take & (occ < DEPTH_V);

  assign mem_req  = issue;
  assign mem_addr = fpc_reg[ADDR_W+1:2];
  assign inst     = inst_reg;
  assign inst_pc  = inst_pc_reg;

  assign rd_ptr_next    = rd_ptr_reg + PW'(1);
  assign wr_ptr_next    = wr_ptr_reg + PW'(1);
  assign head_after_pop = fifo_mem[rd_ptr_next];

  // Head registers track what fifo_mem[rd_ptr] will hold after this edge.
  always_comb begin
    head_data_next = inst_reg;
    head_pc_next   = inst_pc_reg;
    if (pop && (count_reg > CW'(1))) begin
      head_data_next = head_after_pop[31:0];
      head_pc_next   = head_after_pop[63:32];
    end else if (push && ((count_reg == '0) || pop)) begin
      head_data_next = mem_rdata;
      head_pc_next   = flight_pc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {flight_pc_reg, mem_rdata};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_reg       <= RESET_PC;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      inflight_reg  <= 1'b0;
      live_reg      <= 1'b0;
      flight_pc_reg <= '0;
      inst_reg      <= '0;
      inst_pc_reg   <= '0;
`ifdef AD100_FETCH_MISALIGN_EN
      state_reg     <= RUN;
      fault_reg     <= 1'b0;
`endif
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        flight_pc_reg <= fpc_reg;
        live_reg      <= 1'b1;
        fpc_reg       <= fpc_reg + 32'd4;
      end
      if (redirect_take) begin
        fpc_reg    <= {redirect_pc[31:2], 2'b00};
        live_reg   <= 1'b0;
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
`ifdef AD100_FETCH_MISALIGN_EN
        if (misaligned) begin
          state_reg <= FAULT;
          fault_reg <= 1'b1;
        end
`endif
      end else begin
        if (push) begin
          wr_ptr_reg <= wr_ptr_next;
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_next;
        end
        count_reg   <= count_reg + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        inst_reg    <= head_data_next;
        inst_pc_reg <= head_pc_next;
      end
    end
  end

endmodule

// File: tb/tb_ad100_fetch.sv
// Bench for ad100_fetch: directed latency/stall/redirect/reset cases plus random traffic,
// with a PC-stream scoreboard checked by an independent monitor.
module tb_ad100_fetch;

  localparam int          DEPTH    = 2;
  localparam int          ADDR_W   = 30;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;
  logic              fetch_fault;

  int          total = 0;
  int          bad   = 0;
  int          pops  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc;
  bit          faulted_m;
  logic [31:0] mon_e;
  logic        prev_hold;
  logic [31:0] prev_pc;
  logic [31:0] prev_inst;
  logic [31:0] rnd;

  ad100_fetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  // Memory: word k holds 0x1000_0000 + k; garbage when not read.
  always @(posedge clk) begin
    if (mem_req) mem_rdata <= 32'h1000_0000 + {2'b00, mem_addr};
    else         mem_rdata <= $urandom;
  end

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return 32'h1000_0000 + {2'b00, pc[31:2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the delivered stream is consecutive PCs from the latest restart point.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      gen_pc    = RESET_PC;
      faulted_m = 1'b0;
    end else if (redirect && !faulted_m) begin
      exp_q.delete();
`ifdef AD100_FETCH_MISALIGN_EN
      if (redirect_pc[1:0] != 2'b00) faulted_m = 1'b1;
`endif
      gen_pc = {redirect_pc[31:2], 2'b00};
    end
    if (!faulted_m) begin
      while (exp_q.size() < 8) begin
        exp_q.push_back(gen_pc);
        gen_pc = gen_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic wait_first(input logic [31:0] exp_pc, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        found = 1'b1;
        check(name, inst_pc, exp_pc);
      end
      tick();
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL %s: got no inst_valid within 12 cycles expected pc %h", name, exp_pc);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(inst_valid), 32'd1);
        check("hold_pc", inst_pc, prev_pc);
        check("hold_inst", inst, prev_inst);
      end
      if (inst_valid && inst_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL deliver: got pc %h expected no delivery", inst_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("deliver_pc", inst_pc, mon_e);
          check("deliver_inst", inst, word_of(mon_e));
        end
      end
      prev_hold = inst_valid && !inst_ready && !redirect;
      prev_pc   = inst_pc;
      prev_inst = inst;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    gen_pc = RESET_PC; faulted_m = 1'b0;
    repeat (3) tick();

    @(negedge clk);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", {2'b00, mem_addr}, {2'b00, RESET_PC[31:2]});
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    tick();
    rst = 1'b0;

    // Startup latency and streaming
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("lat_req", 32'(mem_req), 32'd1);
      check("lat_addr", {2'b00, mem_addr}, 32'(c));
      check("lat_valid", 32'(inst_valid), 32'(c >= 2));
      tick();
    end

    // Backpressure
    inst_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      if (s >= DEPTH - 1) check("stall_req", 32'(mem_req), 32'd0);
      check("stall_valid", 32'(inst_valid), 32'd1);
      tick();
    end
    inst_ready = 1'b1;
    repeat (6) tick();

    // Redirect with a read in flight
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    @(negedge clk);
    check("redir_req", 32'(mem_req), 32'd0);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("redir_v1", 32'(inst_valid), 32'd0);
    check("redir_req1", 32'(mem_req), 32'd1);
    check("redir_addr1", {2'b00, mem_addr}, 32'h0000_0010);
    tick();
    @(negedge clk);
    check("redir_v2", 32'(inst_valid), 32'd0);
    tick();
    @(negedge clk);
    check("redir_v3", 32'(inst_valid), 32'd1);
    check("redir_pc3", inst_pc, 32'h0000_0040);
    tick();
    repeat (4) tick();

    // Back-to-back redirects
    redirect = 1'b1; redirect_pc = 32'h0000_0080;
    tick();
    redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    wait_first(32'h0000_0100, "b2b_first");
    repeat (4) tick();

    // Misaligned redirect
    redirect = 1'b1; redirect_pc = 32'h0000_0042;
    tick();
    redirect = 1'b0;
`ifdef AD100_FETCH_MISALIGN_EN
    @(negedge clk);
    check("fault_set", 32'(fetch_fault), 32'd1);
    check("fault_req", 32'(mem_req), 32'd0);
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    for (int f = 0; f < 4; f++) begin
      @(negedge clk);
      check("fault_sticky", 32'(fetch_fault), 32'd1);
      check("fault_noreq", 32'(mem_req), 32'd0);
      check("fault_novalid", 32'(inst_valid), 32'd0);
      tick();
    end
    rst = 1'b1;
    #1;
    check("fault_clear", 32'(fetch_fault), 32'd0);
    tick();
    rst = 1'b0;
    wait_first(RESET_PC, "fault_restart");
`else
    wait_first(32'h0000_0040, "misalign_first");
    @(negedge clk);
    check("misalign_nofault", 32'(fetch_fault), 32'd0);
    tick();
`endif
    repeat (4) tick();

    // fpc wrap-around
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    wait_first(32'hFFFF_FFF8, "wrap_first");
    repeat (6) tick();

    // Reset mid-stream
    rst = 1'b1;
    #1;
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_addr", {2'b00, mem_addr}, {2'b00, RESET_PC[31:2]});
    check("mid_rst_valid", 32'(inst_valid), 32'd0);
    check("mid_rst_inst", inst, 32'd0);
    check("mid_rst_pc", inst_pc, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_req1", 32'(mem_req), 32'd1);
    check("mid_rst_addr1", {2'b00, mem_addr}, {2'b00, RESET_PC[31:2]});
    tick();
    wait_first(RESET_PC, "mid_rst_first");

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        rnd = $urandom;
`ifdef AD100_FETCH_MISALIGN_EN
        rnd[1:0] = 2'b00;
`endif
        redirect    = 1'b1;
        redirect_pc = rnd;
      end else begin
        redirect = 1'b0;
      end
      tick();
    end
    redirect = 1'b0;
    inst_ready = 1'b1;
    repeat (6) tick();
    check("progress", 32'(pops > 200), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ad100_fetch.md
Name: ad100_fetch

Overview:
- Instruction fetch/prefetch stage sitting directly upstream of the ad100 CPU decode.
- Drives word addresses into the instruction memory and buffers the returned words in a small FIFO.
- Presents each instruction and its byte PC to the CPU over a valid/ready handshake.
- On a taken branch/jump the CPU issues a redirect; the block flushes the buffer and any in-flight word, then refetches from the new PC.

Parameters:
- DEPTH, 2, FIFO entries (power of two, >= 2; 2 sustains 1 instr/cycle).
- ADDR_W, 30, word-address width (byte PC = {mem_addr, 2'b00}).
- RESET_PC, 32'h0000_0000, byte PC fetched first after reset.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  out  1  memory read strobe this cycle.
- mem_addr  out  ADDR_W  word address of the read.
- mem_rdata  in  32  read data, valid exactly one cycle after mem_req (memory never stalls).
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  32  new byte PC, sampled when redirect=1.
- inst_valid  out  1  inst/inst_pc hold a valid instruction.
- inst_ready  in  1  CPU accepts the head instruction.
- inst  out  32  instruction word at FIFO head.
- inst_pc  out  32  byte PC of inst.
- fetch_fault  out  1  misaligned-redirect fault (see Optional Feature).

Behaviour:
- Reset values (async, immediate): mem_req=0, mem_addr=RESET_PC[ADDR_W+1:2], inst_valid=0, inst=0, inst_pc=0, fetch_fault=0. FIFO empty, in-flight flag clear, fetch pointer fpc=RESET_PC.
- Issue rule: mem_req=1 iff (count + inflight − pop) < DEPTH and not faulted, where pop = inst_valid & inst_ready.
  - When issuing, mem_addr=fpc[ADDR_W+1:2]; fpc advances by 4 at the edge.
  - An in-flight record holds {pc, live} for the single outstanding read.
- Response: in the cycle after an issue, if live, {mem_rdata, pc} is written into the FIFO at the edge.
- Output: inst_valid=(count!=0). inst/inst_pc come from a registered FIFO head.
- Latency: req in cycle N -> inst_valid in N+2. The first req is in the first cycle after rst deasserts.
- Throughput: 1 instruction/cycle with DEPTH>=2 and inst_ready held high.
- Push and pop in the same cycle: count unchanged, data order preserved.
- Full FIFO: no issue, held data stable, no overwrite.
- Wrap-around:
  - Read/write pointers wrap modulo DEPTH.
  - fpc wraps 32'hFFFF_FFFC -> 0 with no fault.
- Redirect (highest priority), at the edge of the redirect cycle:
  - FIFO cleared (count=0).
  - Any outstanding read marked dead; its data is dropped next cycle.
  - fpc=redirect_pc & ~3.
  - A pop in the same cycle is consumed normally, i.e. it is the branch itself.
- No issue in the redirect cycle. The first new req is in N+1 and inst_valid returns in N+3.
- Back-to-back redirects: the last one wins; each kills prior in-flight data.
- Reset mid-operation: all state returns to reset values immediately, and in-flight data is discarded.
- States: RUN (normal) and FAULT (feature only).

Optional Feature:
- Macro AD100_FETCH_MISALIGN_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 moves to FAULT: fetch_fault=1 (sticky until rst), FIFO flushed, mem_req held 0, inst_valid=0.
  - Later redirects are ignored while in FAULT.
- Undefined:
  - redirect_pc[1:0] are ignored (PC aligned down).
  - fetch_fault is tied 0 and no FAULT state exists.

Test Plan:
- Reset release, memory word k = 32'h1000_0000+k, inst_ready=1 -> first mem_req the cycle after reset, mem_addr 0,1,2... each cycle; inst_valid from cycle 2; inst_pc 0,4,8 with inst 32'h1000_0000, …01, …02 on consecutive cycles.
- inst_ready=0 for 5 cycles -> mem_req drops after DEPTH words are buffered or in flight; inst/inst_pc stable; after ready=1, the sequence resumes with no duplicate or missing PC.
- redirect with redirect_pc=32'h0000_0040 while a read is in flight -> stale word not delivered; next delivered inst_pc=0x40, then 0x44, with inst_valid low for 2 cycles.
- redirect on two consecutive cycles (0x80 then 0x100) -> first delivered inst_pc=0x100; 0x80 never appears.
- rst asserted mid-stream -> outputs return to reset values immediately; after release, fetch restarts at RESET_PC.
- With AD100_FETCH_MISALIGN_EN: redirect_pc=32'h0000_0042 -> fetch_fault=1 next cycle, mem_req=0 thereafter, a later aligned redirect is ignored, and only rst clears the fault. Without the macro, the same stimulus gives inst_pc=0x40.
